// File: rtl/sd_card_cmd.sv
// rtl/sd_card_cmd.sv - SD CMD-line responder: receive 48-bit commands, send 48/136-bit responses.
// Optional receive CRC7 check: define SD_CARD_CMD_CRC_CHECK_EN.
module sd_card_cmd (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_sd_clk,
  inout  wire          io_sd_cmd,
  output logic         o_command_valid,
  output logic [5:0]   o_command_index,
  output logic [31:0]  o_command_argument,
  output logic         o_command_crc_error,
  input  logic         i_response_start,
  input  logic         i_response_skip,
  input  logic         i_response_long,
  input  logic [5:0]   i_response_index,
  input  logic [127:0] i_response_data,
  output logic         o_busy
);

  typedef enum logic [2:0] {IDLE, RECEIVE, REPORT, WAIT_RESPONSE, NCR, TRANSMIT} state_t;

  state_t         state, state_next;
  logic           sd_clk_meta, sd_clk_sync, sd_clk_prev;
  logic           cmd_meta, cmd_sync;
  logic           sd_rise, sd_fall;
  logic [7:0]     bit_cnt;
  logic [45:0]    rx_shift;
  logic [46:0]    rx_next;
  logic           rx_last, frame_ok;
  logic [6:0]     crc;
  logic [135:0]   tx_shift;
  logic           tx_long;
  logic [7:0]     tx_len;
  logic           ncr_cnt;
  logic           cmd_oe, cmd_out;

  // One serial step of CRC7, polynomial x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign io_sd_cmd = cmd_oe ? cmd_out : 1'bz;

  // Bring sd_clk and the CMD line into the i_clk domain; keep previous sd_clk for edge strobes.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sd_clk_meta <= 1'b1;
      sd_clk_sync <= 1'b1;
      sd_clk_prev <= 1'b1;
      cmd_meta    <= 1'b1;
      cmd_sync    <= 1'b1;
    end else begin
      sd_clk_meta <= i_sd_clk;
      sd_clk_sync <= sd_clk_meta;
      sd_clk_prev <= sd_clk_sync;
      cmd_meta    <= io_sd_cmd;
      cmd_sync    <= cmd_meta;
    end
  end

  assign sd_rise  = sd_clk_sync & ~sd_clk_prev;
  assign sd_fall  = ~sd_clk_sync & sd_clk_prev;
  // Bits after the start bit: [46] transmission, [45:40] index, [39:8] arg, [7:1] CRC, [0] end.
  assign rx_next  = {rx_shift, cmd_sync};
  assign rx_last  = (state == RECEIVE) && sd_rise && (bit_cnt == 8'd47);
  assign frame_ok = rx_next[46] && rx_next[0];
  assign tx_len   = tx_long ? 8'd136 : 8'd48;

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_next      = state;
    o_command_valid = (state == REPORT);
    o_busy          = (state != IDLE);
    case (state)
      IDLE:          if (sd_rise && !cmd_sync) state_next = RECEIVE;
      RECEIVE:       if (rx_last) state_next = frame_ok ? REPORT : IDLE;
      REPORT:        state_next = WAIT_RESPONSE;
      WAIT_RESPONSE: begin
        if (i_response_skip)       state_next = IDLE;
        else if (i_response_start) state_next = NCR;
      end
      NCR:           if (sd_rise && ncr_cnt) state_next = TRANSMIT;
      TRANSMIT:      if (sd_fall && (bit_cnt == tx_len)) state_next = IDLE;
      default:       state_next = IDLE;
    endcase
  end

  // Shift registers, counters, CRC and line drive for receive and transmit.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      bit_cnt            <= 8'd0;
      rx_shift           <= '0;
      crc                <= 7'd0;
      tx_shift           <= '0;
      tx_long            <= 1'b0;
      ncr_cnt            <= 1'b0;
      cmd_oe             <= 1'b0;
      cmd_out            <= 1'b1;
      o_command_index    <= 6'd0;
      o_command_argument <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          cmd_oe <= 1'b0;
          if (sd_rise && !cmd_sync) begin
            rx_shift <= '0;
            bit_cnt  <= 8'd1;
            crc      <= crc7_step(7'd0, 1'b0);
          end
        end
        RECEIVE: begin
          if (sd_rise) begin
            rx_shift <= rx_next[45:0];
            bit_cnt  <= bit_cnt + 8'd1;
            if (bit_cnt < 8'd40) crc <= crc7_step(crc, cmd_sync);
            if (rx_last && frame_ok) begin
              o_command_index    <= rx_next[45:40];
              o_command_argument <= rx_next[39:8];
            end
          end
        end
        WAIT_RESPONSE: begin
          if (i_response_start && !i_response_skip) begin
            tx_long  <= i_response_long;
            tx_shift <= i_response_long ? {2'b00, 6'h3f, i_response_data[127:1], 1'b1}
                                        : {2'b00, i_response_index, i_response_data[31:0], 96'd0};
            crc      <= 7'd0;
            bit_cnt  <= 8'd0;
            ncr_cnt  <= 1'b0;
          end
        end
        NCR: begin
          if (sd_rise) ncr_cnt <= ~ncr_cnt;
        end
        TRANSMIT: begin
          if (sd_fall) begin
            if (bit_cnt == tx_len) begin
              cmd_oe <= 1'b0;
            end else begin
              cmd_oe  <= 1'b1;
              bit_cnt <= bit_cnt + 8'd1;
              if (tx_long || bit_cnt < 8'd40) begin
                cmd_out  <= tx_shift[135];
                tx_shift <= {tx_shift[134:0], 1'b0};
                if (!tx_long) crc <= crc7_step(crc, tx_shift[135]);
              end else if (bit_cnt < 8'd47) begin
                cmd_out <= crc[6];
                crc     <= {crc[5:0], 1'b0};
              end else begin
                cmd_out <= 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SD_CARD_CMD_CRC_CHECK_EN
  logic crc_err_q;

  // Compare the CRC accumulated over the first 40 bits with the received CRC field.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                 crc_err_q <= 1'b0;
    else if (rx_last && frame_ok) crc_err_q <= (crc != rx_next[7:1]);
  end

  assign o_command_crc_error = crc_err_q;
`else
  logic unused_rx_crc;
  assign unused_rx_crc       = &{1'b0, rx_next[7:1]};
  assign o_command_crc_error = 1'b0;
`endif

endmodule

// File: tb/tb_sd_card_cmd.sv
// tb/tb_sd_card_cmd.sv - directed self-checking bench for sd_card_cmd.
module tb_sd_card_cmd;

  logic         i_clk, i_reset, i_sd_clk;
  wire          cmd_line;
  logic         host_low;
  logic         o_command_valid;
  logic [5:0]   o_command_index;
  logic [31:0]  o_command_argument;
  logic         o_command_crc_error;
  logic         i_response_start, i_response_skip, i_response_long;
  logic [5:0]   i_response_index;
  logic [127:0] i_response_data;
  logic         o_busy;

  int total = 0;
  int bad   = 0;
  int vcount = 0;

  logic [135:0] bits;
  int           hiz;
  bit           ok;

`ifdef SD_CARD_CMD_CRC_CHECK_EN
  localparam logic EXP_BAD_CRC = 1'b1;
`else
  localparam logic EXP_BAD_CRC = 1'b0;
`endif

  localparam logic [127:0] LONG_DATA = 128'h0123456789ABCDEF_FEDCBA9876543210;

  pullup (cmd_line);
  assign cmd_line = host_low ? 1'b0 : 1'bz;

  sd_card_cmd dut (
    .i_clk               (i_clk),
    .i_reset             (i_reset),
    .i_sd_clk            (i_sd_clk),
    .io_sd_cmd           (cmd_line),
    .o_command_valid     (o_command_valid),
    .o_command_index     (o_command_index),
    .o_command_argument  (o_command_argument),
    .o_command_crc_error (o_command_crc_error),
    .i_response_start    (i_response_start),
    .i_response_skip     (i_response_skip),
    .i_response_long     (i_response_long),
    .i_response_index    (i_response_index),
    .i_response_data     (i_response_data),
    .o_busy              (o_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    i_sd_clk = 1'b0;
    #3;
    forever #40 i_sd_clk = ~i_sd_clk;
  end

  always @(negedge i_clk) if (o_command_valid) vcount++;

  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [47:0] f);
    for (int i = 47; i >= 0; i--) begin
      @(negedge i_sd_clk);
      host_low = ~f[i];
    end
    @(negedge i_sd_clk);
    host_low = 1'b0;
    repeat (2) @(negedge i_clk);
  endtask

  task automatic respond(input logic lng, input logic [5:0] idx, input logic [127:0] data);
    @(negedge i_clk);
    i_response_start = 1'b1;
    i_response_long  = lng;
    i_response_index = idx;
    i_response_data  = data;
    @(negedge i_clk);
    i_response_start = 1'b0;
  endtask

  task automatic collect(input int nbits, output logic [135:0] b, output int hz, output bit done);
    int n;
    b = '0; hz = 0; n = 0;
    for (int t = 0; t < 400 && n < nbits; t++) begin
      @(posedge i_sd_clk);
      #1;
      if (dut.cmd_oe !== 1'b1) begin
        if (n == 0) hz++;
      end else begin
        b = {b[134:0], cmd_line};
        n++;
      end
    end
    done = (n == nbits);
  endtask

  task automatic chk_released(input string tag);
    repeat (2) @(posedge i_sd_clk);
    #1;
    chk({tag, "_hiz"}, dut.cmd_oe, 1'b0);
    chk({tag, "_busy"}, o_busy, 1'b0);
  endtask

  initial begin
    i_reset = 1'b1; host_low = 1'b0;
    i_response_start = 1'b0; i_response_skip = 1'b0; i_response_long = 1'b0;
    i_response_index = 6'd0; i_response_data = '0;
    repeat (3) @(negedge i_clk);
    chk("rst_busy",  o_busy, 1'b0);
    chk("rst_valid", o_command_valid, 1'b0);
    chk("rst_index", o_command_index, 6'd0);
    chk("rst_arg",   o_command_argument, 32'd0);
    chk("rst_crce",  o_command_crc_error, 1'b0);
    chk("rst_hiz",   dut.cmd_oe, 1'b0);
    i_reset = 1'b0;
    repeat (20) @(negedge i_clk);

    // start request while IDLE is ignored
    respond(1'b0, 6'd1, 128'd5);
    chk("idle_start_ignored", o_busy, 1'b0);

    // CMD0, then skip
    send_cmd({8'h40, 32'h0000_0000, 7'h4A, 1'b1});
    chk("cmd0_pulses", vcount, 1);
    chk("cmd0_index", o_command_index, 6'd0);
    chk("cmd0_arg",   o_command_argument, 32'd0);
    chk("cmd0_crce",  o_command_crc_error, 1'b0);
    chk("cmd0_busy",  o_busy, 1'b1);
    @(negedge i_clk); i_response_skip = 1'b1;
    @(negedge i_clk); i_response_skip = 1'b0;
    chk("skip_idle", o_busy, 1'b0);

    // CMD8 with short R7 response
    send_cmd({8'h48, 32'h0000_01AA, 7'h43, 1'b1});
    chk("cmd8_pulses", vcount, 2);
    chk("cmd8_index", o_command_index, 6'd8);
    chk("cmd8_arg",   o_command_argument, 32'h0000_01AA);
    chk("cmd8_crce",  o_command_crc_error, 1'b0);
    respond(1'b0, 6'd8, 128'h1AA);
    collect(48, bits, hiz, ok);
    chk("r7_complete", ok, 1'b1);
    chk("r7_ncr", (hiz >= 2), 1'b1);
    chk("r7_frame", bits[47:0], {8'h08, 32'h0000_01AA, crc7(40'h08_0000_01AA), 1'b1});
    chk_released("r7_end");

    // CMD8 with bad CRC, then start and skip together
    send_cmd({8'h48, 32'h0000_01AA, 7'h42, 1'b1});
    chk("badcrc_pulses", vcount, 3);
    chk("badcrc_crce", o_command_crc_error, EXP_BAD_CRC);
    @(negedge i_clk); i_response_skip = 1'b1; i_response_start = 1'b1;
    @(negedge i_clk); i_response_skip = 1'b0; i_response_start = 1'b0;
    chk("both_is_skip", o_busy, 1'b0);
    chk_released("both_line");

    // CMD2 with long R2 response
    send_cmd({8'h42, 32'h0000_0000, crc7(40'h42_0000_0000), 1'b1});
    chk("cmd2_pulses", vcount, 4);
    chk("cmd2_index", o_command_index, 6'd2);
    chk("cmd2_crce",  o_command_crc_error, 1'b0);
    respond(1'b1, 6'd0, LONG_DATA);
    collect(136, bits, hiz, ok);
    chk("r2_complete", ok, 1'b1);
    chk("r2_ncr", (hiz >= 2), 1'b1);
    chk("r2_header", bits[135:128], 8'h3F);
    chk("r2_frame", bits, {2'b00, 6'h3F, LONG_DATA[127:1], 1'b1});
    chk_released("r2_end");

    // bad end bit: discarded
    send_cmd({8'h40, 32'h0000_0000, 7'h4A, 1'b0});
    repeat (4) @(negedge i_clk);
    chk("endbit_no_pulse", vcount, 4);
    chk("endbit_busy", o_busy, 1'b0);
    chk("endbit_keep_index", o_command_index, 6'd2);

    // reset in the middle of a transmit
    send_cmd({8'h48, 32'h0000_01AA, 7'h43, 1'b1});
    chk("cmd8b_pulses", vcount, 5);
    respond(1'b0, 6'd8, 128'h1AA);
    collect(6, bits, hiz, ok);
    chk("mid_tx_reached", ok, 1'b1);
    @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    chk("mid_tx_rst_hiz",  dut.cmd_oe, 1'b0);
    chk("mid_tx_rst_busy", o_busy, 1'b0);
    chk("mid_tx_rst_idx",  o_command_index, 6'd0);
    @(negedge i_clk);
    i_reset = 1'b0;
    repeat (4) @(negedge i_clk);
    chk("mid_tx_no_pulse", vcount, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sd_card_cmd.md
SD_CARD_CMD -- requirements
Module: sd_card_cmd

Card-side (responder) end of the SD CMD line: receives 48-bit host commands, presents them to card logic, transmits R1/R3/R6/R7 (48-bit) or R2 (136-bit) responses.

Interface
REQ-001 SHALL have port i_clk  input  1  system clock; all logic synchronous to its rising edge.
REQ-002 SHALL have port i_reset  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port i_sd_clk  input  1  host SD clock, asynchronous to i_clk, at most i_clk/4.
REQ-004 SHALL have port io_sd_cmd  inout  1  CMD line, open-drain style: drive only while transmitting, else high-Z.
REQ-005 SHALL have port o_command_valid  output  1  one-i_clk pulse per received command.
REQ-006 SHALL have port o_command_index  output  6  received command index.
REQ-007 SHALL have port o_command_argument  output  32  received argument.
REQ-008 SHALL have port o_command_crc_error  output  1  received CRC7 mismatch, qualified by o_command_valid.
REQ-009 SHALL have port i_response_start  input  1  request to send response.
REQ-010 SHALL have port i_response_skip  input  1  no response for this command.
REQ-011 SHALL have port i_response_long  input  1  1 = 136-bit R2, 0 = 48-bit.
REQ-012 SHALL have port i_response_index  input  6  index field, 48-bit responses.
REQ-013 SHALL have port i_response_data  input  128  short: [31:0] payload; long: [127:1] sent verbatim.
REQ-014 SHALL have port o_busy  output  1  high in every state except IDLE.

Function
REQ-015 i_sd_clk SHALL pass a 2-FF synchronizer; rising/falling strobes are one-i_clk pulses on synchronized edges.
REQ-016 CMD SHALL be sampled on rising strobes, driven on falling strobes.
REQ-017 States: IDLE, RECEIVE, REPORT, WAIT_RESPONSE, NCR, TRANSMIT.
REQ-018 IDLE -> RECEIVE when a 0 (start bit) is sampled; 47 further bits shifted MSB first.
REQ-019 After bit 48: transmission bit != 1 or end bit != 1 SHALL discard the command (no pulse) and return to IDLE; otherwise -> REPORT.
REQ-020 REPORT SHALL last one i_clk cycle, pulse o_command_valid with index/argument/crc_error stable until the next o_command_valid, then -> WAIT_RESPONSE.
REQ-021 WAIT_RESPONSE: i_response_skip -> IDLE; i_response_start -> NCR, latching long/index/data that cycle; both high SHALL treat as skip; start/skip ignored in any other state.
REQ-022 NCR SHALL count 2 rising strobes, then -> TRANSMIT, driving the first bit on the next falling strobe.
REQ-023 48-bit frame: 0, 0, index[5:0], data[31:0], CRC7 computed over preceding 40 bits, 1.
REQ-024 136-bit frame: 0, 0, 111111, data[127:1], 1.
REQ-025 CRC7 polynomial x^7+x^3+1, register zeroed at frame start, used for both RX check and TX generation.
REQ-026 After driving the end bit for one full sd_clk period SHALL release to high-Z on the next falling strobe and -> IDLE.
REQ-027 Bit counter SHALL be 8 bits; no wrap within a frame.
REQ-028 Commands arriving outside IDLE SHALL be ignored.

Reset
REQ-029 On i_reset: state IDLE, io_sd_cmd high-Z, o_command_valid 0, o_command_index 0, o_command_argument 0, o_command_crc_error 0, o_busy 0, synchronizers 1.
REQ-030 Reset mid-receive or mid-transmit SHALL abort immediately, release the line the same cycle and emit no pulse.

Configuration
REQ-031 Macro SD_CARD_CMD_CRC_CHECK_EN defined: received CRC7 is checked and o_command_crc_error reports mismatch; command is still reported.
REQ-032 Macro undefined: no RX CRC logic, o_command_crc_error tied 0; TX CRC generation unaffected.

Verification
REQ-033 Host sends CMD0 arg 0x00000000 CRC7 0x4A -> o_command_valid pulse, index 0, argument 0, crc_error 0.
REQ-034 Host sends CMD8 arg 0x000001AA CRC7 0x43, card answers start with index 8, data 0x000001AA -> line stays high-Z for >=2 sd_clk, then 48 bits matching the model frame, CRC7 per model.
REQ-035 CMD8 with CRC7 0x42 -> crc_error 1 with macro defined, 0 without.
REQ-036 CMD2 then long response data 0x0123456789ABCDEF_FEDCBA9876543210 -> 136 bits, header 0x3F, bits [127:1], end bit 1, then high-Z.
REQ-037 Frame with end bit 0 -> no o_command_valid, o_busy returns 0; i_reset asserted mid-TRANSMIT -> line high-Z same cycle, state IDLE.
